// File: rtl/inst_fetch_pkg.sv
// Shared widths, enable levels and the buffer entry type for the fetch stage.
package inst_fetch_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic                   RST_ENABLE  = 1'b1;
   localparam logic                   CHIP_ENABLE = 1'b1;
   localparam logic [INST_W-1:0]      ZERO_WORD   = 32'h0000_0000;
   localparam logic [INST_W-1:0]      NOP_INST    = 32'h0000_0000;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } fetch_entry_t;

   // Pointer advance with wrap at the last used slot.
   function automatic logic [1:0] ptr_next(input logic [1:0] p, input logic [1:0] last);
      return (p == last) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// PC-stage, instruction-ROM and decode-side signals of the fetch stage.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic [INST_ADDR_W-1:0] pc_i;
   logic                   pc_ce_i;
   logic                   fetch_stall_o;
   logic                   rom_ce_o;
   logic [INST_ADDR_W-1:0] rom_addr_o;
   logic [INST_W-1:0]      rom_data_i;
   logic                   flush_i;
   logic                   id_valid_o;
   logic                   id_ready_i;
   logic [INST_ADDR_W-1:0] id_pc_o;
   logic [INST_W-1:0]      id_inst_o;

   // Surrounding pipeline: PC stage, ROM and decode.
   modport master (
      output pc_i, pc_ce_i, rom_data_i, flush_i, id_ready_i,
      input  fetch_stall_o, rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o
   );

   // The fetch stage itself.
   modport slave (
      input  pc_i, pc_ce_i, rom_data_i, flush_i, id_ready_i,
      output fetch_stall_o, rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o
   );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO with synchronous push/pop/clear.
module inst_fifo
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [2:0]   occ
);

   localparam logic [1:0] LAST = 2'(DEPTH - 1);

   // Storage is sized for the largest legal depth so the 2-bit pointers
   // index it directly; slots beyond DEPTH are never written.
   fetch_entry_t mem [4];
   logic [1:0]   rd_ptr;
   logic [1:0]   wr_ptr;

   // Pointer and occupancy bookkeeping; clear wins over push/pop.
   always_ff @(posedge clk) begin
      if (clear) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         occ    <= 3'd0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr, LAST);
         if (pop)  rd_ptr <= ptr_next(rd_ptr, LAST);
         case ({push, pop})
            2'b10:   occ <= occ + 3'd1;
            2'b01:   occ <= occ - 3'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Entry write at the tail.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: issues ROM reads, buffers responses, presents them to decode.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input logic         clk,
   input logic         rst,
   inst_fetch_if.slave bus
);

   logic                   infl;
   logic [INST_ADDR_W-1:0] infl_pc;
   logic [2:0]             occ;
   logic [3:0]             demand;
   logic                   id_valid;
   logic                   deq;
   logic                   capture;
   logic                   stall;
   logic                   rom_ce;
   logic                   clear;
   fetch_entry_t           head;
   fetch_entry_t           push_data;

   assign id_valid = (occ != 3'd0);
   assign deq      = id_valid & bus.id_ready_i;

   // Entries the buffer must still hold after this edge if a new read went out.
   assign demand = {1'b0, occ} + 4'(infl) - 4'(deq);
   assign stall  = (demand >= 4'(DEPTH));

   assign rom_ce  = (bus.pc_ce_i == CHIP_ENABLE) & ~stall & ~bus.flush_i & (rst != RST_ENABLE);
   assign capture = infl & ~bus.flush_i & (rst != RST_ENABLE);
   assign clear   = (rst == RST_ENABLE) | bus.flush_i;

   // Track the read issued this cycle so its response can be tagged next cycle.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         infl    <= 1'b0;
         infl_pc <= ZERO_WORD;
      end else begin
         infl <= rom_ce;
         if (rom_ce) infl_pc <= bus.pc_i;
      end
   end

   assign push_data = '{pc: infl_pc, inst: bus.rom_data_i};

   inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .clear     (clear),
      .push      (capture),
      .push_data (push_data),
      .pop       (deq),
      .head      (head),
      .occ       (occ)
   );

   assign bus.fetch_stall_o = stall;
   assign bus.rom_ce_o      = rom_ce;
   assign bus.rom_addr_o    = bus.pc_i;
   assign bus.id_valid_o    = id_valid;
   assign bus.id_pc_o       = id_valid ? head.pc   : ZERO_WORD;
   assign bus.id_inst_o     = id_valid ? head.inst : NOP_INST;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scenarios plus a random soak, checked against a queue-based model.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inst_fetch_if bus ();

   inst_fetch #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   fetch_entry_t model_q[$];
   logic         pend;
   logic [31:0]  pend_pc;
   logic [31:0]  cur_pc;
   logic         rom_pend;
   logic [31:0]  rom_pend_addr;
   logic         chk_on;
   logic         obs_valid;
   logic         obs_stall;

   function automatic logic [31:0] rom_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare at the falling edge, advance the model.
   task automatic cycle(input logic r, input logic ce, input logic fl, input logic rdy,
                        input logic [31:0] redirect);
      logic        e_valid, e_deq, e_stall, e_ce;
      logic [31:0] e_pc, e_inst;
      int          fill;
      rst            = r;
      bus.pc_ce_i    = ce;
      bus.flush_i    = fl;
      bus.id_ready_i = rdy;
      bus.pc_i       = cur_pc;
      bus.rom_data_i = rom_pend ? rom_of(rom_pend_addr) : $urandom;
      @(negedge clk);
      e_valid = (model_q.size() != 0);
      e_pc    = e_valid ? model_q[0].pc   : 32'h0;
      e_inst  = e_valid ? model_q[0].inst : 32'h0;
      e_deq   = e_valid & rdy;
      fill    = model_q.size() + int'(pend) - int'(e_deq);
      e_stall = (fill >= DEPTH);
      e_ce    = ce & ~e_stall & ~fl & ~r;
      if (chk_on) begin
         chk("id_valid",   32'(bus.id_valid_o),    32'(e_valid));
         chk("id_pc",      bus.id_pc_o,            e_pc);
         chk("id_inst",    bus.id_inst_o,          e_inst);
         chk("stall",      32'(bus.fetch_stall_o), 32'(e_stall));
         chk("rom_ce",     32'(bus.rom_ce_o),      32'(e_ce));
         chk("rom_addr",   bus.rom_addr_o,         cur_pc);
      end
      obs_valid     = bus.id_valid_o;
      obs_stall     = bus.fetch_stall_o;
      rom_pend      = bus.rom_ce_o;
      rom_pend_addr = bus.rom_addr_o;
      if (r || fl) begin
         model_q.delete();
         pend = 1'b0;
      end else begin
         if (e_deq) void'(model_q.pop_front());
         if (pend) model_q.push_back('{pc: pend_pc, inst: rom_of(pend_pc)});
         pend    = e_ce;
         pend_pc = cur_pc;
      end
      if (chk_on && model_q.size() > DEPTH) begin
         n_cmp++;
         n_bad++;
         $error("FAIL model_occ observed=%0d expected<=%0d", model_q.size(), DEPTH);
      end
      if (r)        cur_pc = 32'h0;
      else if (fl)  cur_pc = redirect;
      else if (e_ce) cur_pc = cur_pc + 32'd4;
      @(posedge clk);
      #1;
   endtask

   int first_valid;
   int stall_cnt;

   initial begin
      bus.pc_ce_i = 1'b0; bus.flush_i = 1'b0; bus.id_ready_i = 1'b0;
      bus.pc_i = 32'h0; bus.rom_data_i = 32'h0;
      pend = 1'b0; pend_pc = 32'h0; cur_pc = 32'h0;
      rom_pend = 1'b0; rom_pend_addr = 32'h0;
      chk_on = 1'b0;
      obs_valid = 1'b0; obs_stall = 1'b0;
      @(posedge clk); #1;

      // Reset: first cycle state is unknown, second is checked.
      cycle(1, 0, 0, 0, 0);
      chk_on = 1'b1;
      cycle(1, 1, 0, 1, 0);

      // Streaming with decode always ready.
      first_valid = -1; stall_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, 1, 0);
         if (obs_valid && first_valid < 0) first_valid = i;
         if (obs_stall) stall_cnt++;
      end
      chk("first_valid_lat", 32'(first_valid), 32'd2);
      chk("stream_stalls",   32'(stall_cnt),   32'd0);

      // Backpressure from reset, then release.
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);
      chk("bp_stall", 32'(obs_stall), 32'd1);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 0);

      // Flush with the buffer full, redirect to 0x40.
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 32'h40);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 0);

      // Flush coinciding with a dequeue.
      cycle(0, 1, 1, 1, 32'h100);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 0);

      // Reset mid-stream with the buffer full.
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 0);

      // Random soak.
      for (int i = 0; i < 10000; i++) begin
         cycle(($urandom_range(999) == 0),
               ($urandom_range(9) != 0),
               ($urandom_range(99) < 3),
               ($urandom_range(3) != 0),
               {$urandom_range(16'hFFFF), 2'b00});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
